tpum_mac_acc: RTL
=================

# tpum_mac_acc

Pipelined signed multiply-accumulate stage that sits directly downstream of the TPUM operand register pair (r1/r2). It consumes a stream of 32-bit operand pairs, forms their signed products and sums them into a wide accumulator over a programmed vector length. It returns the dot-product result over a valid/ready handshake. One result is produced per start command.

## Interface
- DATA_W, 32: width of each operand.
- ACC_W, 72: accumulator and result width; must be ≥ 2*DATA_W.
- LEN_W, 8: width of the vector-length field; maximum length is 2^LEN_W-1.

- clk  in  1  clock, all logic rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle command pulse, sampled only in IDLE.
- len  in  LEN_W  number of operand pairs, sampled with start.
- in_valid  in  1  operand pair valid (from r1/r2 stage).
- in_ready  out  1  stage accepts a pair this cycle.
- op_a  in  DATA_W  signed operand (r1).
- op_b  in  DATA_W  signed operand (r2).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_acc  out  ACC_W  signed accumulated result.
- busy  out  1  high in any state other than IDLE.
- overflow  out  1  sticky saturation flag for the current result.

## Operation
- FSM states: IDLE, ACCUM, DRAIN, DONE.
- IDLE: in_ready=0, out_valid=0. start=1 with len>0 → ACCUM; remaining count loaded with len, accumulator and overflow cleared. start=1 with len=0 → DONE with accumulator 0.
- ACCUM: in_ready=1 while remaining>0. A pair is accepted on in_valid&&in_ready; remaining decrements. in_valid low stalls without penalty. Acceptance of the last pair → DRAIN.
- Pipeline stage 1: signed DATA_W×DATA_W product registered (2*DATA_W bits) with a valid bit.
- Pipeline stage 2: product sign-extended to ACC_W and added to the accumulator when stage-1 valid is set.
- DRAIN: in_ready=0. Waits until stage-1 valid has been consumed, then → DONE.
- DONE: out_valid=1, out_acc holds the accumulator and stays stable until out_valid&&out_ready. That handshake → IDLE.
- start outside IDLE is ignored; len is not re-sampled.
- op_a/op_b are don't-care when the pair is not accepted.
- Reset at any point returns the block to IDLE and clears the accumulator, the pipeline valid bit and overflow. There is no partial result output.

## Timing
- Reset values: in_ready=0, out_valid=0, out_acc=0, busy=0, overflow=0.
- start sampled in cycle S → busy=1 and in_ready=1 from cycle S+1 (len>0).
- start sampled in cycle S with len=0 → out_valid=1 from cycle S+1.
- Last pair accepted in cycle T → product visible in T+1, accumulated at end of T+1, out_valid=1 from cycle T+2.
- Throughput: one pair per cycle. Minimum command turnaround is len+3 cycles when out_ready is held high.
- out_valid&&out_ready in cycle D → IDLE in D+1. A start in D+1 is accepted.
- busy falls in the same cycle as IDLE entry.

## Configuration
- Macro: TPUM_MAC_SAT_EN.
- Defined:
  - Each stage-2 addition saturates to signed ACC_W max or min on overflow.
  - overflow sets sticky and holds until the next start is accepted or reset.
- Undefined:
  - Accumulator wraps modulo 2^ACC_W.
  - overflow is tied to 0.
- Both builds are otherwise cycle-identical.

## Test plan
- Basic dot product:
  - Stimulus: start, len=3, pairs (2,3), (4,5), (-1,7) back-to-back; out_ready=1.
  - Response: out_acc=19 exactly 2 cycles after the third accept; busy low 1 cycle after the out handshake.
- Zero length:
  - Stimulus: start, len=0.
  - Response: in_ready never rises; out_valid=1 next cycle with out_acc=0.
- Backpressure:
  - Stimulus: len=4, all pairs (1,1), in_valid toggled 1,0,1,0; out_ready held low 5 cycles.
  - Response: out_acc=4 held stable while out_valid=1; a second start during DONE is ignored.
- Signed extremes:
  - Stimulus: len=2, pairs (0x80000000,0x80000000) and (0x80000000,0x7FFFFFFF).
  - Response: out_acc=2^62 - 2^62 + 2^31 = 0x80000000, sign-correct in ACC_W.
- Saturation, with TPUM_MAC_SAT_EN and ACC_W=64:
  - Stimulus: 3 pairs (0x80000000,0x80000000).
  - Response: out_acc=0x7FFFFFFFFFFFFFFF, overflow=1.
  - Without the macro: wrapped value 0xC000000000000000, overflow=0.
- Reset mid-op:
  - Stimulus: rst_n low after 2 of 5 pairs are accepted, then released; new start with len=1, pair (3,3).
  - Response: out_valid=0, busy=0, out_acc=0 during reset; after release out_acc=9, with no residue from the aborted command.

Source files
------------

// File: rtl/tpum_mac_acc.sv
// Signed multiply-accumulate stage behind the r1/r2 operand registers. It forms a dot product over a programmed length.
// Build option TPUM_MAC_SAT_EN: saturating accumulation with a sticky overflow flag (default: wrap, overflow tied 0).
module tpum_mac_acc #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 72,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic              busy,
    output logic              overflow
);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

    state_t                     state, state_nxt;
    logic [LEN_W-1:0]           remaining;
    logic                       accept;
    logic                       cmd_go;
    logic                       p_vld;
    logic signed [2*DATA_W-1:0] a_ext, b_ext, prod;
    logic [ACC_W-1:0]           prod_ext, acc, sum, acc_nxt;

    assign in_ready  = (state == ACCUM) && (remaining != '0);
    assign accept    = in_valid && in_ready;
    assign cmd_go    = (state == IDLE) && start;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_acc   = acc;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (len == '0) ? DONE : ACCUM;
            ACCUM:   if (accept && remaining == LEN_W'(1)) state_nxt = DRAIN;
            // The last product is always live in the first DRAIN cycle and is folded in on this edge.
            DRAIN:   state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            remaining <= '0;
        end else begin
            state <= state_nxt;
            if (cmd_go)      remaining <= len;
            else if (accept) remaining <= remaining - LEN_W'(1);
        end
    end

    // Stage 1: full-width signed product; operands pre-extended so the truncated multiply is exact.
    assign a_ext = {{DATA_W{op_a[DATA_W-1]}}, op_a};
    assign b_ext = {{DATA_W{op_b[DATA_W-1]}}, op_b};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_vld <= 1'b0;
            prod  <= '0;
        end else begin
            p_vld <= accept;
            if (accept) prod <= a_ext * b_ext;
        end
    end

    generate
        if (ACC_W > 2*DATA_W) begin : g_sext
            assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
        end else begin : g_nosext
            assign prod_ext = prod;
        end
    endgenerate

    // Stage 2: accumulate.
    assign sum = acc + prod_ext;

`ifdef TPUM_MAC_SAT_EN
    logic add_ovf;
    logic ovf_q;

    assign add_ovf = (acc[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
    assign acc_nxt = !add_ovf ? sum :
                     acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                ovf_q <= 1'b0;
        else if (cmd_go)           ovf_q <= 1'b0;
        else if (p_vld && add_ovf) ovf_q <= 1'b1;
    end

    assign overflow = ovf_q;
`else
    assign acc_nxt  = sum;
    assign overflow = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     acc <= '0;
        else if (cmd_go) acc <= '0;
        else if (p_vld)  acc <= acc_nxt;
    end

endmodule
